// File: rtl/gear_shift_pkg.sv
// rtl/gear_shift_pkg.sv - shared FSM state type and default timing constants for gear_shift_ctrl
package gear_shift_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACT_UP   = 2'd1,
        ACT_DOWN = 2'd2,
        LOCKOUT  = 2'd3
    } shiftState_t;

    localparam int DEF_NUM_GEARS       = 6;
    localparam int DEF_SHIFT_CYCLES    = 5000000;
    localparam int DEF_NEUTRAL_CYCLES  = 2500000;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_LOCKOUT_CYCLES  = 1000000;

    // Largest of the three timer loads; sizes the shared down-counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, level debouncer and rising-edge pulse for one button
module btn_debounce
    import gear_shift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnAsync,
    output logic btnRise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
            $fatal(1, "btn_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [1:0]       syncFf;
    logic             syncLevel;
    logic             stableLevel;
    logic [CNT_W-1:0] dbCnt;

    assign syncLevel = syncFf[1];

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncFf <= 2'b00;
        end else begin
            syncFf <= {syncFf[0], btnAsync};
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES consecutive cycles;
    // flag a one-cycle pulse when the accepted level goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableLevel <= 1'b0;
            dbCnt       <= '0;
            btnRise     <= 1'b0;
        end else begin
            btnRise <= 1'b0;
            if (syncLevel != stableLevel) begin
                if (dbCnt == CNT_LAST) begin
                    stableLevel <= syncLevel;
                    dbCnt       <= '0;
                    btnRise     <= syncLevel;
                end else begin
                    dbCnt <= dbCnt + CNT_W'(1);
                end
            end else begin
                dbCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gear_shift_ctrl.sv
// rtl/gear_shift_ctrl.sv - sequential gearbox shift controller with timed actuator pulses and lockout
module gear_shift_ctrl
    import gear_shift_pkg::*;
#(
    parameter int NUM_GEARS       = DEF_NUM_GEARS,
    parameter int SHIFT_CYCLES    = DEF_SHIFT_CYCLES,
    parameter int NEUTRAL_CYCLES  = DEF_NEUTRAL_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           up_btn,
    input  logic                           down_btn,
    input  logic                           neutral_btn,
    output logic                           up_out,
    output logic                           down_out,
    output logic [$clog2(NUM_GEARS+1)-1:0] gear,
    output logic [NUM_GEARS:0]             gear_led,
    output logic                           busy
);

    localparam int GW      = $clog2(NUM_GEARS + 1);
    localparam int LED_W   = NUM_GEARS + 1;
    localparam int CNT_MAX = maxOf3(SHIFT_CYCLES, NEUTRAL_CYCLES, LOCKOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Counter loads are length-1 so the pulse lasts exactly the requested cycle count.
    localparam logic [CNT_W-1:0] SHIFT_LOAD   = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] NEUTRAL_LOAD = CNT_W'(NEUTRAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [GW-1:0]    TOP_GEAR     = GW'(NUM_GEARS);

    generate
        if (NUM_GEARS < 1 || NUM_GEARS > 14) begin : gBadGears
            $fatal(1, "gear_shift_ctrl: NUM_GEARS must be in 1..14");
        end
        if (SHIFT_CYCLES < 1 || NEUTRAL_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : gBadTiming
            $fatal(1, "gear_shift_ctrl: SHIFT/NEUTRAL/LOCKOUT_CYCLES must be at least 1");
        end
        if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
            $fatal(1, "gear_shift_ctrl: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic upRise;
    logic downRise;
    logic neutralRise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUpDb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btnAsync(up_btn),
        .btnRise (upRise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDownDb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btnAsync(down_btn),
        .btnRise (downRise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uNeutralDb (
        .clk     (clk),
        .rst_n   (rst_n),
        .btnAsync(neutral_btn),
        .btnRise (neutralRise)
    );

    shiftState_t      state;
    shiftState_t      stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [GW-1:0]    gearNext;
    logic [LED_W-1:0] ledNext;
    logic             upNext;
    logic             downNext;

    logic             reqUp;
    logic             reqDown;
    logic [CNT_W-1:0] reqLoad;
    logic [GW-1:0]    reqGear;

    // Translate a single button edge into the actuator direction, pulse length and target gear.
    // Neutral sits between 1 and 2 on the drum: from 0 the first gear is a down-stroke, and
    // neutral is reached with a half up-stroke from 1 or a half down-stroke from 2.
    always_comb begin
        reqUp   = 1'b0;
        reqDown = 1'b0;
        reqLoad = SHIFT_LOAD;
        reqGear = gear;
        unique case ({upRise, downRise, neutralRise})
            3'b100: begin
                if (gear == '0) begin
                    reqDown = 1'b1;
                    reqGear = GW'(1);
                end else if (gear < TOP_GEAR) begin
                    reqUp   = 1'b1;
                    reqGear = gear + GW'(1);
                end
            end
            3'b010: begin
                if (gear == '0) begin
                    reqDown = 1'b1;
                    reqGear = GW'(1);
                end else if (gear >= GW'(2) && NUM_GEARS >= 2) begin
                    reqDown = 1'b1;
                    reqGear = gear - GW'(1);
                end
            end
            3'b001: begin
                if (gear == GW'(1)) begin
                    reqUp   = 1'b1;
                    reqLoad = NEUTRAL_LOAD;
                    reqGear = '0;
                end else if (gear == GW'(2) && NUM_GEARS >= 2) begin
                    reqDown = 1'b1;
                    reqLoad = NEUTRAL_LOAD;
                    reqGear = '0;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic: start a pulse from IDLE, time it out, then hold off for the lockout.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        gearNext  = gear;
        upNext    = up_out;
        downNext  = down_out;
        unique case (state)
            IDLE: begin
                if (reqUp) begin
                    stateNext = ACT_UP;
                    upNext    = 1'b1;
                    cntNext   = reqLoad;
                    gearNext  = reqGear;
                end else if (reqDown) begin
                    stateNext = ACT_DOWN;
                    downNext  = 1'b1;
                    cntNext   = reqLoad;
                    gearNext  = reqGear;
                end
            end
            ACT_UP, ACT_DOWN: begin
                if (cnt == '0) begin
                    stateNext = LOCKOUT;
                    upNext    = 1'b0;
                    downNext  = 1'b0;
                    cntNext   = LOCKOUT_LOAD;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            LOCKOUT: begin
                if (cnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        ledNext = LED_W'(1) << gearNext;
    end

    // State, timer, gear and registered actuator/indicator outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gear     <= '0;
            gear_led <= LED_W'(1);
            up_out   <= 1'b0;
            down_out <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            gear     <= gearNext;
            gear_led <= ledNext;
            up_out   <= upNext;
            down_out <= downNext;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// tb/tb_gear_shift_ctrl.sv - scoreboard testbench for gear_shift_ctrl
module tb_gear_shift_ctrl;

    localparam int NG   = 6;
    localparam int DB   = 4;
    localparam int SH   = 10;
    localparam int NE   = 5;
    localparam int LK   = 3;
    localparam int DIR_UP   = 1;
    localparam int DIR_DOWN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_btn = 1'b0;
    logic       down_btn = 1'b0;
    logic       neutral_btn = 1'b0;
    logic       up_out;
    logic       down_out;
    logic [2:0] gear;
    logic [6:0] gear_led;
    logic       busy;

    typedef struct {
        int dir;
        int len;
        int gear;
    } pulse_t;

    pulse_t expQ[$];
    int testsRun = 0;
    int testsFailed = 0;
    int invErr = 0;

    gear_shift_ctrl #(
        .NUM_GEARS      (NG),
        .SHIFT_CYCLES   (SH),
        .NEUTRAL_CYCLES (NE),
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .neutral_btn(neutral_btn),
        .up_out     (up_out),
        .down_out   (down_out),
        .gear       (gear),
        .gear_led   (gear_led),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures every actuator pulse and the lockout after it, compares against the queue.
    int curLen = 0;
    int curDir = 0;
    int curGear = 0;
    int lockLen = 0;
    bit lockActive = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            curLen = 0;
            lockActive = 1'b0;
        end else begin
            if (up_out && down_out) begin
                invErr++;
                $display("FAIL overlap: up_out=%0b down_out=%0b", up_out, down_out);
            end
            if (gear_led !== (7'b1 << gear)) begin
                invErr++;
                $display("FAIL led_consistency: gear_led=%b gear=%0d", gear_led, gear);
            end
            if (up_out || down_out) begin
                if (curLen == 0) begin
                    curDir = up_out ? DIR_UP : DIR_DOWN;
                    curGear = int'(gear);
                end
                curLen++;
                if (!busy) begin
                    invErr++;
                    $display("FAIL busy_in_pulse: got 0 expected 1");
                end
            end else begin
                if (curLen > 0) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_pulse_dir", curDir, 0);
                    end else begin
                        pulse_t e;
                        e = expQ.pop_front();
                        check("pulse_dir", curDir, e.dir);
                        check("pulse_len", curLen, e.len);
                        check("pulse_gear", curGear, e.gear);
                    end
                    curLen = 0;
                    lockActive = 1'b1;
                    lockLen = 0;
                end
                if (lockActive) begin
                    if (busy) lockLen++;
                    else begin
                        check("lockout_len", lockLen, LK);
                        lockActive = 1'b0;
                    end
                end
            end
        end
    end

    task automatic expectPulse(input int dir, input int len, input int g);
        pulse_t e;
        e.dir = dir;
        e.len = len;
        e.gear = g;
        expQ.push_back(e);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_timeout", int'(busy), 0);
    endtask

    // sel bit0 = up, bit1 = down, bit2 = neutral
    task automatic press(input int sel, input int hold);
        up_btn = sel[0];
        down_btn = sel[1];
        neutral_btn = sel[2];
        repeat (hold) @(posedge clk);
        #1;
        up_btn = 1'b0;
        down_btn = 1'b0;
        neutral_btn = 1'b0;
        waitIdle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic waitUpOut();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!up_out && n < 40);
        check("up_out_seen", int'(up_out), 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gear", int'(gear), 0);
        check("rst_led", int'(gear_led), 1);
        check("rst_up", int'(up_out), 0);
        check("rst_down", int'(down_out), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Held up from neutral: one down-stroke into first
        expectPulse(DIR_DOWN, SH, 1);
        press(1, 20);
        check("g1_gear", int'(gear), 1);
        check("g1_led", int'(gear_led), 7'b0000010);

        // Neutral from 1: half up-stroke
        expectPulse(DIR_UP, NE, 0);
        press(4, 12);
        check("n_from1_gear", int'(gear), 0);

        // Neutral from 2: half down-stroke
        expectPulse(DIR_DOWN, SH, 1);
        press(1, 12);
        expectPulse(DIR_UP, SH, 2);
        press(1, 12);
        check("g2_gear", int'(gear), 2);
        expectPulse(DIR_DOWN, NE, 0);
        press(4, 12);
        check("n_from2_gear", int'(gear), 0);

        // Neutral in gear 0 is ignored
        press(4, 12);
        check("n_in0_gear", int'(gear), 0);

        // Climb to top
        expectPulse(DIR_DOWN, SH, 1);
        press(1, 12);
        for (int g = 2; g <= NG; g++) begin
            expectPulse(DIR_UP, SH, g);
            press(1, 12);
        end
        check("top_gear", int'(gear), 6);
        check("top_led", int'(gear_led), 7'b1000000);
        press(1, 12);
        check("top_up_ignored", int'(gear), 6);
        expectPulse(DIR_DOWN, SH, 5);
        press(2, 12);
        check("top_down_gear", int'(gear), 5);

        // Down request ignored in gear 1
        // (reached later) -- simultaneous edges and glitch first
        press(3, 12);
        check("simul_gear", int'(gear), 5);
        press(1, 2);
        check("glitch_gear", int'(gear), 5);

        // Down pressed so its edge lands inside the lockout after an upshift
        expectPulse(DIR_UP, SH, 6);
        up_btn = 1'b1;
        waitUpOut();
        repeat (5) @(posedge clk);
        #1;
        down_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        up_btn = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        down_btn = 1'b0;
        waitIdle();
        repeat (10) @(posedge clk);
        #1;
        check("lockout_discard_gear", int'(gear), 6);

        // Reset mid up-stroke
        expectPulse(DIR_DOWN, SH, 5);
        press(2, 12);
        up_btn = 1'b1;
        waitUpOut();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_up", int'(up_out), 0);
        check("midrst_down", int'(down_out), 0);
        check("midrst_gear", int'(gear), 0);
        check("midrst_led", int'(gear_led), 1);
        check("midrst_busy", int'(busy), 0);
        up_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expectPulse(DIR_DOWN, SH, 1);
        press(1, 12);
        check("resume_gear", int'(gear), 1);

        // Down in gear 1 is ignored
        press(2, 12);
        check("g1_down_ignored", int'(gear), 1);

        repeat (5) @(posedge clk);
        #1;
        check("pending_pulses", expQ.size(), 0);
        check("invariants", invErr, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gear_shift_ctrl.md
GEAR_SHIFT_CTRL -- requirements
Module: gear_shift_ctrl

Interface
REQ-001 Parameter NUM_GEARS, default 6, forward gears above neutral; legal range 1..14.
REQ-002 Parameter SHIFT_CYCLES, default 5000000, clk cycles of a full gear-change actuator pulse.
REQ-003 Parameter NEUTRAL_CYCLES, default 2500000, clk cycles of a half-shift pulse into neutral.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000, clk cycles a button must hold a new level to be accepted.
REQ-005 Parameter LOCKOUT_CYCLES, default 1000000, clk cycles of dead time after every pulse.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 up_btn  input  1  upshift request, asynchronous to clk, active high.
REQ-009 down_btn  input  1  downshift request, asynchronous to clk, active high.
REQ-010 neutral_btn  input  1  find-neutral request, asynchronous to clk, active high.
REQ-011 up_out  output  1  upshift actuator drive, registered.
REQ-012 down_out  output  1  downshift actuator drive, registered.
REQ-013 gear  output  $clog2(NUM_GEARS+1)  current gear; 0 = neutral, 1..NUM_GEARS = forward gears.
REQ-014 gear_led  output  NUM_GEARS+1  one-hot gear indicator; bit g set when gear == g.
REQ-015 busy  output  1  high during ACT_UP, ACT_DOWN and LOCKOUT.

Function
REQ-016 Each button SHALL pass a 2-flop synchroniser, then a debouncer that updates its output only after DEBOUNCE_CYCLES consecutive cycles at the new level.
REQ-017 Only a rising edge of a debounced button SHALL count as a request; a held button SHALL produce exactly one request.
REQ-018 FSM states SHALL be IDLE, ACT_UP, ACT_DOWN and LOCKOUT.
REQ-019 In IDLE, a request SHALL be accepted only if exactly one button edge occurs in that cycle; simultaneous edges SHALL be discarded.
REQ-020 Gear 0 with up or down request: go to ACT_DOWN with length SHIFT_CYCLES; gear becomes 1.
REQ-021 Gear 1 with up request: go to ACT_UP with SHIFT_CYCLES; gear becomes 2. Down request ignored.
REQ-022 Gear 1 with neutral request: go to ACT_UP with NEUTRAL_CYCLES; gear becomes 0.
REQ-023 Gear 2 with neutral request: go to ACT_DOWN with NEUTRAL_CYCLES; gear becomes 0.
REQ-024 Gear g, 2 <= g < NUM_GEARS: up request gives ACT_UP, gear g+1; down request gives ACT_DOWN, gear g-1; both with SHIFT_CYCLES.
REQ-025 Gear NUM_GEARS: up request ignored; down request gives ACT_DOWN to NUM_GEARS-1. Neutral request ignored in gears 0 and >= 3.
REQ-026 gear SHALL update in the same clock edge that leaves IDLE, i.e. it shows the commanded gear.
REQ-027 up_out or down_out SHALL rise on the edge that leaves IDLE and stay high for exactly the selected cycle count.
REQ-028 After the pulse, the FSM SHALL enter LOCKOUT with both outputs low for exactly LOCKOUT_CYCLES, then return to IDLE.
REQ-029 Requests arriving in ACT_UP, ACT_DOWN or LOCKOUT SHALL be discarded, not queued.
REQ-030 up_out and down_out SHALL never be high in the same cycle.
REQ-031 A single shared down-counter SHALL be used for pulse and lockout timing. Width: $clog2 of the maximum of the cycle parameters, plus 1.
REQ-032 gear_led SHALL be registered, consistent with gear in the same cycle, and exactly one-hot at all times.

Reset
REQ-033 While rst_n is low: state = IDLE; gear = 0; gear_led = 1; up_out, down_out and busy = 0; counters and synchronisers cleared.
REQ-034 Reset asserted mid-pulse SHALL drop the actuator output immediately (asynchronously), and gear SHALL return to 0.

Structure
REQ-035 Package gear_shift_pkg SHALL hold the FSM state typedef and the default cycle-count constants.
REQ-036 Sub-module btn_debounce (synchroniser, debouncer and rising-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.
REQ-037 Parameter legality SHALL be checked at elaboration; an out-of-range parameter SHALL be a fatal error.

Verification (NUM_GEARS=6, DEBOUNCE=4, SHIFT=10, NEUTRAL=5, LOCKOUT=3)
REQ-038 Reset, then up_btn held 20 cycles: down_out high for exactly 10 cycles, gear=1, gear_led=0000010, single shift only.
REQ-039 From gear 1, neutral_btn pressed: up_out high for 5 cycles, gear=0. From gear 2, neutral_btn pressed: down_out high for 5 cycles, gear=0.
REQ-040 Climb to gear 6, then press up again: no output pulse and gear stays 6. Press down: down_out for 10 cycles, gear=5.
REQ-041 up_btn and down_btn rise together: no pulse, gear unchanged. A 2-cycle glitch on up_btn: no pulse.
REQ-042 Press down_btn during the lockout that follows an upshift: request discarded, busy falls 3 cycles after the pulse ends.
REQ-043 rst_n pulsed low in cycle 4 of an up_out pulse: up_out low within the same cycle, gear=0, then normal operation resumes.
